// File: rtl/mem_responder.sv
// mem_responder: memory/MMIO responder for the control FSM's MAR/MDR handshake.
// A request is captured while idle, waits a fixed latency, and then raises r.
// r stays high until mio_en is seen low. Behind the handshake are a
// 2^ADDR_BITS x 16 RAM and four memory-mapped registers:
//   xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR.
// Any other address outside the RAM reads x0000 and ignores writes.
//
// Ports:
//   i_Clk       rising-edge clock
//   reset_      asynchronous, active-low reset
//   mio_en      access request, held high until the data has been taken
//   rw          0 = read, 1 = write (sampled at access start)
//   mar         access address (sampled at access start)
//   mdr_in      write data (sampled at access start)
//   r           ready: access complete, rdata valid
//   rdata       read data returned to the MDR
//   kbd_strobe  one-cycle pulse: new character on kbd_char
//   kbd_char    keyboard character
//   disp_ack    one-cycle pulse: display consumed a character
//   ddr_data    character sent to the display
//   ddr_valid   one-cycle pulse: ddr_data is new
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        i_Clk,
  input  logic        reset_,
  input  logic        mio_en,
  input  logic        rw,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  output logic        r,
  output logic [15:0] rdata,
  input  logic        kbd_strobe,
  input  logic [7:0]  kbd_char,
  input  logic        disp_ack,
  output logic [7:0]  ddr_data,
  output logic        ddr_valid
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  logic [1:0]  state;
  logic [3:0]  count;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        rw_q;

  logic        kbd_ready;
  logic [7:0]  kbdr;
  logic        disp_ready;

  logic [15:0] mem [2**ADDR_BITS];

  logic        complete;
  logic [15:0] rd_value;

  function automatic logic is_mmio(input logic [15:0] a);
    return (a == KBSR_ADDR) || (a == KBDR_ADDR) ||
           (a == DSR_ADDR)  || (a == DDR_ADDR);
  endfunction

  // MMIO decode takes priority so the registers stay reachable even when
  // the RAM is configured to span the whole 16-bit space.
  function automatic logic is_ram(input logic [15:0] a);
    return !is_mmio(a) && ((32'(a) >> ADDR_BITS) == 32'd0);
  endfunction

  // The single edge on which the access takes effect and r rises.
  assign complete = (state == WAIT) && (count == 4'd0);

  // Read data is taken from register values before this edge's updates,
  // so a KBDR read racing a new keystroke returns the old character.
  always_comb begin
    rd_value = 16'h0000;
    if (addr_q == KBSR_ADDR)
      rd_value = {kbd_ready, 15'b0};
    else if (addr_q == KBDR_ADDR)
      rd_value = {8'h00, kbdr};
    else if (addr_q == DSR_ADDR)
      rd_value = {disp_ready, 15'b0};
    else if (addr_q == DDR_ADDR)
      rd_value = {8'h00, ddr_data};
    else if (is_ram(addr_q))
      rd_value = mem[addr_q[ADDR_BITS-1:0]];
  end

  // Handshake FSM. A write echoes its data back on rdata so the MDR is
  // left holding what was written.
  always_ff @(posedge i_Clk or negedge reset_) begin
    if (!reset_) begin
      state   <= IDLE;
      count   <= 4'd0;
      r       <= 1'b0;
      rdata   <= 16'h0000;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rw_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mio_en) begin
            addr_q  <= mar;
            wdata_q <= mdr_in;
            rw_q    <= rw;
            count   <= is_mmio(mar) ? 4'd0 : 4'(WAIT_CYCLES);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (count == 4'd0) begin
            state <= DONE;
            r     <= 1'b1;
            rdata <= rw_q ? wdata_q : rd_value;
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE: begin
          if (!mio_en) begin
            r     <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          r     <= 1'b0;
        end
      endcase
    end
  end

  // RAM has no reset; a reset clears 'complete' via the FSM, so an
  // aborted write never lands.
  always_ff @(posedge i_Clk) begin
    if (complete && rw_q && is_ram(addr_q))
      mem[addr_q[ADDR_BITS-1:0]] <= wdata_q;
  end

  // Keyboard: a new keystroke beats a simultaneous KBDR read clearing ready.
  always_ff @(posedge i_Clk or negedge reset_) begin
    if (!reset_) begin
      kbd_ready <= 1'b0;
      kbdr      <= 8'h00;
    end else if (kbd_strobe) begin
      kbd_ready <= 1'b1;
      kbdr      <= kbd_char;
    end else if (complete && !rw_q && (addr_q == KBDR_ADDR)) begin
      kbd_ready <= 1'b0;
    end
  end

  // Display: a DDR write beats a simultaneous acknowledge.
  always_ff @(posedge i_Clk or negedge reset_) begin
    if (!reset_) begin
      disp_ready <= 1'b1;
      ddr_data   <= 8'h00;
      ddr_valid  <= 1'b0;
    end else begin
      ddr_valid <= 1'b0;
      if (complete && rw_q && (addr_q == DDR_ADDR)) begin
        ddr_data   <= wdata_q[7:0];
        ddr_valid  <= 1'b1;
        disp_ready <= 1'b0;
      end else if (disp_ack) begin
        disp_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: self-checking bench for mem_responder. Directed scenarios
// plus randomized accesses are compared against a transaction-level model
// (associative-array RAM and plain variables for the device registers).
module tb_mem_responder;

  localparam int ADDR_BITS   = 8;
  localparam int WAIT_CYCLES = 3;

  logic        i_Clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        mio_en = 1'b0;
  logic        rw = 1'b0;
  logic [15:0] mar = 16'h0000;
  logic [15:0] mdr_in = 16'h0000;
  logic        r;
  logic [15:0] rdata;
  logic        kbd_strobe = 1'b0;
  logic [7:0]  kbd_char = 8'h00;
  logic        disp_ack = 1'b0;
  logic [7:0]  ddr_data;
  logic        ddr_valid;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] ref_mem [int];
  int          ram_addrs [$];
  logic        ref_kbd_ready = 1'b0;
  logic [7:0]  ref_kbdr = 8'h00;
  logic        ref_disp_ready = 1'b1;
  logic [7:0]  ref_ddr = 8'h00;
  int          exp_pulses = 0;
  int          valid_cnt = 0;

  mem_responder #(.ADDR_BITS(ADDR_BITS), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .i_Clk(i_Clk), .reset_(reset_), .mio_en(mio_en), .rw(rw), .mar(mar),
    .mdr_in(mdr_in), .r(r), .rdata(rdata), .kbd_strobe(kbd_strobe),
    .kbd_char(kbd_char), .disp_ack(disp_ack), .ddr_data(ddr_data),
    .ddr_valid(ddr_valid)
  );

  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) if (ddr_valid === 1'b1) valid_cnt++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit isMmio(input logic [15:0] a);
    return a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06;
  endfunction

  function automatic bit isRam(input logic [15:0] a);
    return !isMmio(a) && (int'(a) < (1 << ADDR_BITS));
  endfunction

  function automatic logic [15:0] modelRead(input logic [15:0] a);
    case (a)
      16'hFE00: return {ref_kbd_ready, 15'b0};
      16'hFE02: return {8'h00, ref_kbdr};
      16'hFE04: return {ref_disp_ready, 15'b0};
      16'hFE06: return {8'h00, ref_ddr};
      default:  return (isRam(a) && ref_mem.exists(int'(a))) ? ref_mem[int'(a)] : 16'h0000;
    endcase
  endfunction

  // One complete handshake. Optional keystroke / display-ack pulses land on
  // the predicted completion edge; drop_early releases mio_en during WAIT.
  task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [15:0] d,
                               input int hold, input bit drop_early,
                               input bit strobe_done, input logic [7:0] sch,
                               input bit ack_done);
    int lat;
    int edges;
    bit got;
    logic [15:0] exp;
    lat = isMmio(a) ? 1 : WAIT_CYCLES + 1;
    exp = modelRead(a);
    @(negedge i_Clk);
    mio_en = 1'b1; rw = w; mar = a; mdr_in = d;
    @(posedge i_Clk);
    @(negedge i_Clk);
    // Later bus changes must not disturb the captured access
    mar = 16'($urandom); rw = 1'($urandom); mdr_in = 16'($urandom);
    if (drop_early) mio_en = 1'b0;
    edges = 0; got = 1'b0;
    while (!got && edges < 40) begin
      if (edges == lat - 1) begin
        kbd_strobe = strobe_done; kbd_char = sch; disp_ack = ack_done;
      end
      @(posedge i_Clk); edges++;
      @(negedge i_Clk);
      kbd_strobe = 1'b0; disp_ack = 1'b0;
      got = (r === 1'b1);
    end
    checkOutput($sformatf("lat_%h", a), edges, lat);
    if (!w) checkOutput($sformatf("rdata_%h", a), rdata, exp);
    // Model side effects of the completion edge
    if (!w && a == 16'hFE02) ref_kbd_ready = 1'b0;
    if (strobe_done) begin ref_kbd_ready = 1'b1; ref_kbdr = sch; end
    if (ack_done) ref_disp_ready = 1'b1;
    if (w && a == 16'hFE06) begin
      ref_disp_ready = 1'b0; ref_ddr = d[7:0]; exp_pulses++;
    end
    if (w && isRam(a)) begin
      if (!ref_mem.exists(int'(a))) ram_addrs.push_back(int'(a));
      ref_mem[int'(a)] = d;
    end
    if (!drop_early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge i_Clk); @(negedge i_Clk);
        checkOutput("r_hold", r, 1'b1);
        if (!w) checkOutput("rdata_hold", rdata, exp);
      end
      mio_en = 1'b0;
    end
    @(posedge i_Clk); @(negedge i_Clk);
    checkOutput("r_clear", r, 1'b0);
    checkOutput("ddr_data", ddr_data, ref_ddr);
    checkOutput("ddr_pulses", valid_cnt, exp_pulses);
  endtask

  task automatic doRead(input logic [15:0] a, input int hold);
    applyStimulus(1'b0, a, 16'h0000, hold, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic doWrite(input logic [15:0] a, input logic [15:0] d);
    applyStimulus(1'b1, a, d, 0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic pulseKbd(input logic [7:0] ch);
    @(negedge i_Clk); kbd_strobe = 1'b1; kbd_char = ch;
    @(negedge i_Clk); kbd_strobe = 1'b0;
    ref_kbd_ready = 1'b1; ref_kbdr = ch;
  endtask

  task automatic pulseAck();
    @(negedge i_Clk); disp_ack = 1'b1;
    @(negedge i_Clk); disp_ack = 1'b0;
    ref_disp_ready = 1'b1;
  endtask

  initial begin
    logic [15:0] a;
    int sel;
    #12;
    checkOutput("rst_r", r, 1'b0);
    checkOutput("rst_rdata", rdata, 16'h0000);
    checkOutput("rst_ddr_data", ddr_data, 8'h00);
    checkOutput("rst_ddr_valid", ddr_valid, 1'b0);
    @(negedge i_Clk); reset_ = 1'b1;

    // RAM write then read with a long hold on mio_en
    doWrite(16'h0005, 16'h1234);
    doRead(16'h0005, 5);
    doWrite(16'h0000, 16'hBEEF);
    doWrite(16'h0010, 16'hAAAA);

    // Keyboard path
    pulseKbd(8'h41);
    doRead(16'hFE00, 0);
    doRead(16'hFE02, 0);
    doRead(16'hFE00, 1);

    // Display path
    doWrite(16'hFE06, 16'h0058);
    doRead(16'hFE04, 0);
    pulseAck();
    doRead(16'hFE04, 0);
    doRead(16'hFE06, 0);

    // Unmapped address: reads zero, write does not alias into RAM
    doRead(16'h4000, 0);
    doWrite(16'h4000, 16'h7777);
    doRead(16'h0000, 0);

    // Keystroke on the KBDR read completion edge wins
    pulseKbd(8'h11);
    applyStimulus(1'b0, 16'hFE02, 16'h0000, 0, 1'b0, 1'b1, 8'h22, 1'b0);
    doRead(16'hFE00, 0);
    doRead(16'hFE02, 0);
    // Overwrite while ready
    pulseKbd(8'h33);
    pulseKbd(8'h44);
    doRead(16'hFE02, 0);

    // Display ack on the DDR write completion edge loses
    applyStimulus(1'b1, 16'hFE06, 16'h00A5, 0, 1'b0, 1'b0, 8'h00, 1'b1);
    doRead(16'hFE04, 0);

    // mio_en dropped during WAIT: access still completes, r pulses once
    applyStimulus(1'b1, 16'h0007, 16'hCAFE, 0, 1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 16'h0007, 16'h0000, 0, 1'b1, 1'b0, 8'h00, 1'b0);

    // Randomized mix
    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        a = 16'($urandom_range(0, (1 << ADDR_BITS) - 1));
        applyStimulus(1'b1, a, 16'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0),
                      1'b0, 8'h00, 1'b0);
      end else if (sel <= 5) begin
        a = 16'(ram_addrs[$urandom_range(0, ram_addrs.size() - 1)]);
        applyStimulus(1'b0, a, 16'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0),
                      1'b0, 8'h00, 1'b0);
      end else if (sel <= 8) begin
        a = 16'hFE00 + 16'(2 * $urandom_range(0, 3));
        applyStimulus(1'($urandom), a, 16'($urandom), $urandom_range(0, 2),
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                      8'($urandom), 1'($urandom_range(0, 2) == 0));
      end else begin
        a = 16'($urandom_range(256, 65535));
        if (isMmio(a)) a = 16'h8000;
        applyStimulus(1'($urandom), a, 16'($urandom), $urandom_range(0, 2), 1'b0,
                      1'b0, 8'h00, 1'b0);
      end
      if ($urandom_range(0, 4) == 0) pulseKbd(8'($urandom));
      if ($urandom_range(0, 4) == 0) pulseAck();
    end

    // Reset in the middle of a RAM write's WAIT
    doWrite(16'hFE06, 16'h0012);
    @(negedge i_Clk);
    mio_en = 1'b1; rw = 1'b1; mar = 16'h0010; mdr_in = 16'h5555;
    @(posedge i_Clk); @(negedge i_Clk); @(posedge i_Clk);
    #2 reset_ = 1'b0;
    #1;
    checkOutput("abort_r", r, 1'b0);
    checkOutput("abort_ddr_valid", ddr_valid, 1'b0);
    mio_en = 1'b0;
    @(negedge i_Clk); reset_ = 1'b1;
    ref_kbd_ready = 1'b0; ref_kbdr = 8'h00; ref_disp_ready = 1'b1; ref_ddr = 8'h00;
    checkOutput("abort_rdata", rdata, 16'h0000);
    checkOutput("abort_ddr_data", ddr_data, 8'h00);
    doRead(16'hFE04, 0);
    doRead(16'h0010, 0);
    doRead(16'hFE00, 0);
    doRead(16'hFE06, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
